// File: rtl/sb_mem_slave_if.sv
// System-bus signal bundle between one master and the sb_mem_slave word RAM.
// Handshake: a read word transfers on every cycle sb_data_valid_o is high (no back-pressure);
// a write word transfers on every cycle sb_data_valid_i is high while sb_busy_o is low.
interface sb_mem_slave_if;
  logic        sb_begin_transaction_i;
  logic        sb_end_transaction_i;
  logic        sb_data_valid_i;
  logic [31:0] sb_address_data_i;
  logic [3:0]  sb_byte_enables_i;
  logic [7:0]  sb_burst_size_i;
  logic        sb_read_n_write_i;
  logic [31:0] sb_address_data_o;
  logic        sb_data_valid_o;
  logic        sb_end_transaction_o;
  logic        sb_busy_o;
  logic        sb_error_o;

  modport slave (
    input  sb_begin_transaction_i, sb_end_transaction_i, sb_data_valid_i,
           sb_address_data_i, sb_byte_enables_i, sb_burst_size_i, sb_read_n_write_i,
    output sb_address_data_o, sb_data_valid_o, sb_end_transaction_o, sb_busy_o, sb_error_o
  );

  modport master (
    output sb_begin_transaction_i, sb_end_transaction_i, sb_data_valid_i,
           sb_address_data_i, sb_byte_enables_i, sb_burst_size_i, sb_read_n_write_i,
    input  sb_address_data_o, sb_data_valid_o, sb_end_transaction_o, sb_busy_o, sb_error_o
  );
endinterface

// File: rtl/sb_mem_slave.sv
// Word-addressed system-bus RAM slave with programmable read latency and write-busy stall.
// All bus outputs are zero while the slave is not driving so they can be OR-ed onto a shared bus.
module sb_mem_slave #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          ADDR_BITS    = 10,
  parameter int          READ_LATENCY = 4,
  parameter int          WRITE_BUSY   = 5
) (
  input  logic          sb_clock_i,
  input  logic          sb_reset_i,
  sb_mem_slave_if.slave bus,
  output logic [2:0]    o_dbg_state
);
  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int EW    = ADDR_BITS + 10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_BURST = 3'd2,
    RD_END   = 3'd3,
    WR_BUSY  = 3'd4,
    WR_DATA  = 3'd5,
    ERROR    = 3'd6
  } state_e;

  state_e               r_state;
  logic [ADDR_BITS-1:0] r_wa;
  logic [8:0]           r_left;
  logic [15:0]          r_cnt;
  logic                 r_valid;
  logic                 r_end;
  logic                 r_busy;
  logic                 r_err;
  logic [31:0]          r_rdata;
  logic [31:0]          r_mem [DEPTH];

  logic [ADDR_BITS-1:0] w_wa;
  logic [ADDR_BITS-1:0] w_rd_addr;
  logic [8:0]           w_len;
  logic [EW-1:0]        w_last;
  logic                 w_hit;
  logic                 w_ok;
  logic                 w_we;

  // Address-phase decode: the burst must lie entirely inside the window, no wrap.
  assign w_wa   = bus.sb_address_data_i[ADDR_BITS+1:2];
  assign w_len  = {1'b0, bus.sb_burst_size_i} + 9'd1;
  assign w_hit  = (bus.sb_address_data_i[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
  assign w_last = EW'(w_wa) + EW'(w_len);
  assign w_ok   = w_hit && (w_last <= EW'(DEPTH));

  // In IDLE the RAM is addressed straight from the bus so a latency of 1 still has data ready.
  assign w_rd_addr = (r_state == IDLE) ? w_wa : r_wa;

  assign w_we = sb_reset_i && (r_state == WR_DATA) && bus.sb_data_valid_i && (r_left != 9'd0);

  always_ff @(posedge sb_clock_i) begin
    r_rdata <= r_mem[w_rd_addr];
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.sb_byte_enables_i[b]) r_mem[r_wa][8*b +: 8] <= bus.sb_address_data_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge sb_clock_i) begin
    if (!sb_reset_i) begin
      r_state <= IDLE;
      r_wa    <= '0;
      r_left  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_end   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_end   <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.sb_begin_transaction_i) begin
            if (!w_ok) begin
              r_err   <= 1'b1;
              r_state <= ERROR;
            end else if (bus.sb_read_n_write_i) begin
              if (READ_LATENCY <= 1) begin
                r_valid <= 1'b1;
                r_wa    <= w_wa + ADDR_BITS'(1);
                r_left  <= w_len - 9'd1;
                r_state <= RD_BURST;
              end else begin
                r_wa    <= w_wa;
                r_left  <= w_len;
                r_cnt   <= 16'(READ_LATENCY - 2);
                r_state <= RD_WAIT;
              end
            end else begin
              r_wa   <= w_wa;
              r_left <= w_len;
              if (WRITE_BUSY > 0) begin
                r_busy  <= 1'b1;
                r_cnt   <= 16'(WRITE_BUSY - 1);
                r_state <= WR_BUSY;
              end else begin
                r_state <= WR_DATA;
              end
            end
          end
        end
        RD_WAIT: begin
          if (bus.sb_end_transaction_i) begin
            r_state <= IDLE;
          end else if (r_cnt == 16'd0) begin
            r_valid <= 1'b1;
            r_wa    <= r_wa + ADDR_BITS'(1);
            r_left  <= r_left - 9'd1;
            r_state <= RD_BURST;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        RD_BURST: begin
          if (bus.sb_end_transaction_i) begin
            r_state <= IDLE;
          end else if (r_left != 9'd0) begin
            r_valid <= 1'b1;
            r_wa    <= r_wa + ADDR_BITS'(1);
            r_left  <= r_left - 9'd1;
          end else begin
            r_end   <= 1'b1;
            r_state <= RD_END;
          end
        end
        RD_END: r_state <= IDLE;
        WR_BUSY: begin
          if (bus.sb_end_transaction_i) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (r_cnt == 16'd0) begin
            r_busy  <= 1'b0;
            r_state <= WR_DATA;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        WR_DATA: begin
          // A word beyond the announced length is dropped and flagged.
          if (bus.sb_data_valid_i && (r_left == 9'd0)) begin
            r_err   <= 1'b1;
            r_state <= ERROR;
          end else begin
            if (bus.sb_data_valid_i) begin
              r_wa   <= r_wa + ADDR_BITS'(1);
              r_left <= r_left - 9'd1;
            end
            if (bus.sb_end_transaction_i) r_state <= IDLE;
          end
        end
        ERROR:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.sb_data_valid_o      = r_valid;
  assign bus.sb_address_data_o    = r_valid ? r_rdata : 32'h0;
  assign bus.sb_end_transaction_o = r_end;
  assign bus.sb_busy_o            = r_busy;
  assign bus.sb_error_o           = r_err;
  assign o_dbg_state              = r_state;
endmodule

// File: tb/tb_sb_mem_slave.sv
// Randomized bench for sb_mem_slave: two instances (long latency/busy and latency 1/no busy)
// share one OR-ed output bus and are checked against a word-level memory model.
module tb_sb_mem_slave;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam int AB0 = 11, RL0 = 4, WB0 = 5;
  localparam logic [31:0] BASE1 = 32'h0004_0000;
  localparam int AB1 = 4, RL1 = 1, WB1 = 0;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int          sel = 0;
  logic        m_begin = 1'b0, m_end = 1'b0, m_dv = 1'b0, m_rnw = 1'b0;
  logic [31:0] m_ad = 32'h0;
  logic [3:0]  m_be = 4'h0;
  logic [7:0]  m_bs = 8'h0;
  logic [2:0]  st0, st1;

  sb_mem_slave_if bus0();
  sb_mem_slave_if bus1();

  assign bus0.sb_begin_transaction_i = m_begin && (sel == 0);
  assign bus0.sb_end_transaction_i   = m_end && (sel == 0);
  assign bus0.sb_data_valid_i        = m_dv && (sel == 0);
  assign bus0.sb_address_data_i      = (sel == 0) ? m_ad : 32'h0;
  assign bus0.sb_byte_enables_i      = (sel == 0) ? m_be : 4'h0;
  assign bus0.sb_burst_size_i        = (sel == 0) ? m_bs : 8'h0;
  assign bus0.sb_read_n_write_i      = m_rnw && (sel == 0);
  assign bus1.sb_begin_transaction_i = m_begin && (sel == 1);
  assign bus1.sb_end_transaction_i   = m_end && (sel == 1);
  assign bus1.sb_data_valid_i        = m_dv && (sel == 1);
  assign bus1.sb_address_data_i      = (sel == 1) ? m_ad : 32'h0;
  assign bus1.sb_byte_enables_i      = (sel == 1) ? m_be : 4'h0;
  assign bus1.sb_burst_size_i        = (sel == 1) ? m_bs : 8'h0;
  assign bus1.sb_read_n_write_i      = m_rnw && (sel == 1);

  // Shared bus: both slaves' outputs are OR-ed, so an idle slave must stay at zero.
  logic        o_vld, o_end, o_busy, o_err;
  logic [31:0] o_data;
  assign o_vld  = bus0.sb_data_valid_o | bus1.sb_data_valid_o;
  assign o_end  = bus0.sb_end_transaction_o | bus1.sb_end_transaction_o;
  assign o_busy = bus0.sb_busy_o | bus1.sb_busy_o;
  assign o_err  = bus0.sb_error_o | bus1.sb_error_o;
  assign o_data = bus0.sb_address_data_o | bus1.sb_address_data_o;

  sb_mem_slave #(.BASE_ADDR(BASE0), .ADDR_BITS(AB0), .READ_LATENCY(RL0), .WRITE_BUSY(WB0)) u_dut0 (
    .sb_clock_i(clk), .sb_reset_i(rst_n), .bus(bus0.slave), .o_dbg_state(st0));
  sb_mem_slave #(.BASE_ADDR(BASE1), .ADDR_BITS(AB1), .READ_LATENCY(RL1), .WRITE_BUSY(WB1)) u_dut1 (
    .sb_clock_i(clk), .sb_reset_i(rst_n), .bus(bus1.slave), .o_dbg_state(st1));

  // scoreboard / reference model
  logic [31:0] mdl [int];
  logic [31:0] exp_q[$];
  bit          known_q[$];
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int lat(input int s);
    return (s == 1) ? RL1 : RL0;
  endfunction

  function automatic int wbusy(input int s);
    return (s == 1) ? WB1 : WB0;
  endfunction

  function automatic int key(input int s, input int wa);
    return s * 65536 + wa;
  endfunction

  // Window check done as byte-offset arithmetic from the base.
  function automatic void decode(input int s, input logic [31:0] addr, input int len,
                                 output bit ok, output int wa);
    longint a, base, off;
    int depth;
    a     = longint'({32'h0, addr});
    base  = (s == 1) ? longint'({32'h0, BASE1}) : longint'({32'h0, BASE0});
    depth = 1 << ((s == 1) ? AB1 : AB0);
    off   = a - base;
    ok    = 1'b0;
    wa    = 0;
    if (off >= 0 && off < 4 * longint'(depth)) begin
      wa = int'(off / 4);
      ok = (wa + len <= depth);
    end
  endfunction

  function automatic void mdl_write(input int s, input int wa, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] m;
    int kk;
    kk = key(s, wa);
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
    if (be == 4'hF) mdl[kk] = d;
    else if (mdl.exists(kk)) mdl[kk] = (mdl[kk] & ~m) | (d & m);
  endfunction

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bus(input string tag, input bit ev, input bit ee, input bit eb, input bit er,
                         input logic [31:0] ed, input bit cd);
    @(negedge clk);
    chk({tag, ".ctl"}, {28'h0, o_vld, o_end, o_busy, o_err}, {28'h0, ev, ee, eb, er});
    if (cd) chk({tag, ".dat"}, o_data, ed);
  endtask

  task automatic chk_err(input string tag);
    chk_bus({tag, ".err"}, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
    next_cycle();
    chk_bus({tag, ".post"}, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    next_cycle();
  endtask

  // stop_k: cycle after begin in which the master aborts (or reset is pulled when stop_rst).
  task automatic rd(input int s, input logic [31:0] addr, input int bs, input int stop_k,
                    input bit stop_rst, input bit end_w_begin, input string tag);
    int len, rl, wa, kk;
    bit ok, stopped, ev, ee, cd;
    logic [31:0] ed;
    len = bs + 1;
    rl  = lat(s);
    stopped = 1'b0;
    decode(s, addr, len, ok, wa);
    sel = s; m_begin = 1'b1; m_rnw = 1'b1; m_ad = addr; m_bs = 8'(bs); m_end = end_w_begin;
    next_cycle();
    m_begin = 1'b0; m_rnw = 1'b0; m_ad = 32'h0; m_bs = 8'h0; m_end = 1'b0;
    if (!ok) begin
      chk_err(tag);
      return;
    end
    exp_q.delete();
    known_q.delete();
    for (int i = 0; i < len; i++) begin
      kk = key(s, wa + i);
      known_q.push_back(mdl.exists(kk));
      exp_q.push_back(mdl.exists(kk) ? mdl[kk] : 32'h0);
    end
    for (int k = 1; k <= rl + len + 1; k++) begin
      if (k == stop_k) begin
        if (stop_rst) rst_n = 1'b0;
        else m_end = 1'b1;
      end
      ev = !stopped && (k >= rl) && (k < rl + len);
      ee = !stopped && (k == rl + len);
      ed = 32'h0;
      cd = 1'b1;
      if (ev) begin
        ed = exp_q.pop_front();
        cd = known_q.pop_front();
      end
      chk_bus(tag, ev, ee, 1'b0, 1'b0, ed, cd);
      next_cycle();
      if (k == stop_k) begin
        stopped = 1'b1;
        rst_n = 1'b1;
        m_end = 1'b0;
      end
    end
  endtask

  // Master holds each word through the busy window; ovf sends one word beyond the length.
  task automatic wr(input int s, input logic [31:0] addr, input int bs, input bit ovf,
                    input bit end_last, input bit rnd, input logic [31:0] d0,
                    input logic [3:0] be0, input bit rnd_be, input string tag);
    int len, n, wb, wa, i, k;
    bit ok, eb;
    logic [31:0] d;
    logic [3:0] be;
    len = bs + 1;
    n   = ovf ? len + 1 : len;
    wb  = wbusy(s);
    decode(s, addr, len, ok, wa);
    sel = s; m_begin = 1'b1; m_rnw = 1'b0; m_ad = addr; m_bs = 8'(bs);
    next_cycle();
    m_begin = 1'b0; m_bs = 8'h0; m_ad = 32'h0;
    if (!ok) begin
      chk_err(tag);
      return;
    end
    i = 0;
    k = 1;
    d  = rnd ? $urandom : d0;
    be = rnd_be ? 4'($urandom_range(0, 15)) : be0;
    while (i < n) begin
      eb = (k <= wb);
      m_dv = 1'b1; m_ad = d; m_be = be;
      m_end = !ovf && end_last && !eb && (i == n - 1);
      chk_bus(tag, 1'b0, 1'b0, eb, 1'b0, 32'h0, 1'b1);
      next_cycle();
      if (!eb) begin
        if (i < len) mdl_write(s, wa + i, d, be);
        i++;
        d  = rnd ? $urandom : d0 + 32'(i);
        be = rnd_be ? 4'($urandom_range(0, 15)) : be0;
      end
      k++;
    end
    m_dv = 1'b0; m_ad = 32'h0; m_be = 4'h0; m_end = 1'b0;
    if (ovf) begin
      chk_bus({tag, ".ovf"}, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
      next_cycle();
    end else if (!end_last) begin
      m_end = 1'b1;
      chk_bus({tag, ".end"}, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      next_cycle();
      m_end = 1'b0;
    end
    chk_bus({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    next_cycle();
  endtask

  initial begin
    int s, bs, sk;
    logic [31:0] a;

    next_cycle();
    next_cycle();
    chk_bus("reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("reset.st0", 32'(st0), 32'h0);
    chk("reset.st1", 32'(st1), 32'h0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Directed cases on the latency-4 / busy-5 instance
    wr(0, BASE0 + 32'h1000, 0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 4'hF, 1'b0, "t1_wr");
    rd(0, BASE0 + 32'h1000, 0, 0, 1'b0, 1'b0, "t2_rd");
    wr(0, BASE0, 7, 1'b0, 1'b0, 1'b0, 32'h0, 4'hF, 1'b0, "t3_wr");
    rd(0, BASE0, 7, 0, 1'b0, 1'b0, "t3_rd");
    wr(0, BASE0 + 32'h20, 0, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 4'hF, 1'b0, "t4_init");
    wr(0, BASE0 + 32'h20, 0, 1'b0, 1'b1, 1'b0, 32'h0000AB00, 4'b0010, 1'b0, "t4_be");
    rd(0, BASE0 + 32'h20, 0, 0, 1'b0, 1'b0, "t4_rd");
    chk("t4_model", mdl[key(0, 8)], 32'hFFFFABFF);
    rd(0, BASE0 + 32'(4 * (1 << AB0)), 0, 0, 1'b0, 1'b0, "t5_miss");
    rd(0, BASE0 + 32'(4 * ((1 << AB0) - 1)), 3, 0, 1'b0, 1'b0, "t5_oob");
    wr(0, BASE0 + 32'(4 * ((1 << AB0) - 2)), 2, 1'b0, 1'b1, 1'b0, 32'h0, 4'hF, 1'b0, "t5_wr_oob");
    rd(0, BASE0 + 32'(4 * ((1 << AB0) - 1)), 0, 0, 1'b0, 1'b1, "t5_last_beg_end");
    wr(0, BASE0 + 32'h100, 7, 1'b0, 1'b1, 1'b1, 32'h0, 4'hF, 1'b0, "t6_fill");
    rd(0, BASE0 + 32'h100, 7, RL0 + 2, 1'b1, 1'b0, "t6_rst");
    rd(0, BASE0 + 32'h100, 7, 0, 1'b0, 1'b0, "t6_after");
    wr(0, BASE0 + 32'h40, 2, 1'b0, 1'b1, 1'b0, 32'h11110000, 4'hF, 1'b0, "t7_fill");
    wr(0, BASE0 + 32'h40, 1, 1'b1, 1'b0, 1'b0, 32'h22220000, 4'hF, 1'b0, "t7_ovf");
    rd(0, BASE0 + 32'h40, 2, 0, 1'b0, 1'b0, "t7_rd");
    wr(0, BASE0 + 32'h44, 0, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 4'h0, 1'b0, "t8_be0");
    rd(0, BASE0 + 32'h44, 0, 0, 1'b0, 1'b0, "t8_rd");
    rd(0, BASE0, 7, RL0 + 3, 1'b0, 1'b0, "t9_abort");
    rd(0, BASE0, 7, 2, 1'b0, 1'b0, "t9_abort_wait");

    // Latency-1 / no-busy instance
    wr(1, BASE1, 15, 1'b0, 1'b1, 1'b1, 32'h0, 4'hF, 1'b0, "d1_fill");
    rd(1, BASE1, 15, 0, 1'b0, 1'b0, "d1_rd");
    rd(1, BASE1 + 32'(4 * 15), 1, 0, 1'b0, 1'b0, "d1_oob");
    rd(1, BASE1 + 32'h40, 0, 0, 1'b0, 1'b0, "d1_miss");
    rd(1, BASE0, 0, 0, 1'b0, 1'b0, "d1_miss0");
    rd(1, BASE1 + 32'(4 * 15) + 32'h3, 0, 0, 1'b0, 1'b0, "d1_last");
    rd(1, BASE1, 3, 2, 1'b0, 1'b0, "d1_abort");
    wr(1, BASE1 + 32'h8, 2, 1'b1, 1'b0, 1'b1, 32'h0, 4'hF, 1'b0, "d1_ovf");
    rd(1, BASE1, 7, 0, 1'b0, 1'b0, "d1_rd2");

    // Random traffic over both windows
    wr(0, BASE0, 63, 1'b0, 1'b1, 1'b1, 32'h0, 4'hF, 1'b0, "r_fill");
    for (int t = 0; t < 60; t++) begin
      s  = int'($urandom_range(0, 1));
      bs = int'($urandom_range(0, 7));
      if (s == 0) a = BASE0 + 32'(4 * $urandom_range(0, 70)) + 32'($urandom_range(0, 3));
      else        a = BASE1 + 32'(4 * $urandom_range(0, 17)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        sk = 0;
        if ($urandom_range(0, 3) == 0) sk = int'($urandom_range(1, lat(s) + bs));
        rd(s, a, bs, sk, 1'b0, ($urandom_range(0, 3) == 0), "rnd_rd");
      end else begin
        wr(s, a, bs, ($urandom_range(0, 5) == 0), ($urandom_range(0, 1) == 1), 1'b1, 32'h0,
           4'hF, ($urandom_range(0, 2) == 0), "rnd_wr");
      end
    end
    rd(0, BASE0, 63, 0, 1'b0, 1'b0, "r_final0");
    rd(1, BASE1, 15, 0, 1'b0, 1'b0, "r_final1");

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
